// File: rtl/branch_resolve_unit.sv
// Execute-stage branch unit: decodes a B-type instruction, evaluates its condition and
// target, and returns taken/target/mispredict/redirect results through a 1- or 2-deep pipeline.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_redirect_pc,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic             out_misaligned,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [6:0]      dec_opcode;
  logic [2:0]      dec_funct3;
  logic            dec_legal;
  logic [12:0]     dec_imm13;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic [XLEN-1:0] dec_pc4;
  logic            dec_eq;
  logic            dec_lt;
  logic            dec_ltu;
  logic            dec_cond;

  // Register-number fields are not needed: operand values arrive already read.
  logic unused_inst_bits;
  assign unused_inst_bits = ^in_inst[24:15];

  always_comb begin
    dec_opcode = in_inst[6:0];
    dec_funct3 = in_inst[14:12];
    dec_legal  = (dec_opcode == OP_BRANCH) && (dec_funct3 != 3'b010) && (dec_funct3 != 3'b011);
    dec_imm13  = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    dec_imm    = {{(XLEN-13){dec_imm13[12]}}, dec_imm13};
    dec_target = in_pc + dec_imm;
    dec_pc4    = in_pc + XLEN'(4);
    dec_eq     = (in_rs1 == in_rs2);
    dec_lt     = ($signed(in_rs1) < $signed(in_rs2));
    dec_ltu    = (in_rs1 < in_rs2);
    case (dec_funct3)
      3'b000:  dec_cond = dec_eq;
      3'b001:  dec_cond = !dec_eq;
      3'b100:  dec_cond = dec_lt;
      3'b101:  dec_cond = !dec_lt;
      3'b110:  dec_cond = dec_ltu;
      3'b111:  dec_cond = !dec_ltu;
      default: dec_cond = 1'b0;
    endcase
  end

  // Fields feeding the resolution logic; taken straight from decode or from stage 1.
  logic            rs_legal;
  logic            rs_cond;
  logic [XLEN-1:0] rs_target;
  logic [XLEN-1:0] rs_pc4;
  logic            rs_pred_taken;
  logic [XLEN-1:0] rs_pred_target;

  logic            res_taken;
  logic [XLEN-1:0] res_redirect;
  logic            res_mispredict;
  logic            res_misaligned;
  logic            res_illegal;

  always_comb begin
    res_taken      = rs_legal && rs_cond;
    res_redirect   = res_taken ? rs_target : rs_pc4;
    res_mispredict = rs_legal && ((rs_pred_taken != res_taken) ||
                                  (res_taken && (rs_pred_target != rs_target)));
    res_misaligned = res_taken && rs_target[1];
    res_illegal    = !rs_legal;
  end

  logic out_fire;
  logic out_can_load;
  logic out_load;

  assign out_fire     = out_valid && out_ready;
  assign out_can_load = !out_valid || out_ready;

  if (STAGES == 1) begin : g_one_stage
    assign in_ready       = out_can_load;
    assign out_load       = in_valid && in_ready && !flush;
    assign rs_legal       = dec_legal;
    assign rs_cond        = dec_cond;
    assign rs_target      = dec_target;
    assign rs_pc4         = dec_pc4;
    assign rs_pred_taken  = in_pred_taken;
    assign rs_pred_target = in_pred_target;
  end else begin : g_two_stage
    logic            s1_valid;
    logic            s1_legal;
    logic            s1_cond;
    logic [XLEN-1:0] s1_target;
    logic [XLEN-1:0] s1_pc4;
    logic            s1_pred_taken;
    logic [XLEN-1:0] s1_pred_target;
    logic            s1_adv;
    logic            in_fire;

    assign s1_adv   = s1_valid && out_can_load;
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_load = s1_adv && !flush;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid       <= 1'b0;
        s1_legal       <= 1'b0;
        s1_cond        <= 1'b0;
        s1_target      <= '0;
        s1_pc4         <= '0;
        s1_pred_taken  <= 1'b0;
        s1_pred_target <= '0;
      end else begin
        if (flush)       s1_valid <= 1'b0;
        else if (in_fire) s1_valid <= 1'b1;
        else if (s1_adv)  s1_valid <= 1'b0;
        if (in_fire) begin
          s1_legal       <= dec_legal;
          s1_cond        <= dec_cond;
          s1_target      <= dec_target;
          s1_pc4         <= dec_pc4;
          s1_pred_taken  <= in_pred_taken;
          s1_pred_target <= in_pred_target;
        end
      end
    end

    assign rs_legal       = s1_legal;
    assign rs_cond        = s1_cond;
    assign rs_target      = s1_target;
    assign rs_pc4         = s1_pc4;
    assign rs_pred_taken  = s1_pred_taken;
    assign rs_pred_target = s1_pred_target;
  end

  // Output register: result fields only change on a load, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_target      <= '0;
      out_redirect_pc <= '0;
      out_mispredict  <= 1'b0;
      out_illegal     <= 1'b0;
      out_misaligned  <= 1'b0;
    end else begin
      if (flush)         out_valid <= 1'b0;
      else if (out_load)  out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (out_load) begin
        out_taken       <= res_taken;
        out_target      <= rs_target;
        out_redirect_pc <= res_redirect;
        out_mispredict  <= res_mispredict;
        out_illegal     <= res_illegal;
        out_misaligned  <= res_misaligned;
      end
    end
  end

  // Statistics count every legal handshake, including one that coincides with a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (out_fire && !out_illegal) begin
      if (stat_branches != CNT_MAX) stat_branches <= stat_branches + CNT_W'(1);
      if (out_mispredict && (stat_mispredicts != CNT_MAX))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (XLEN=32, STAGES=2, CNT_W=2) with hand-computed results.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic        in_pred_taken = 1'b0;
  logic [31:0] in_pred_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_taken;
  logic [31:0] out_target;
  logic [31:0] out_redirect_pc;
  logic        out_mispredict;
  logic        out_illegal;
  logic        out_misaligned;
  logic [1:0]  stat_branches;
  logic [1:0]  stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit #(.XLEN(32), .STAGES(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_redirect_pc(out_redirect_pc),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal),
    .out_misaligned(out_misaligned),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] b_inst(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic pt, input logic [31:0] ptgt);
    in_inst = inst; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  // One entry through an empty pipeline, full result check, then a single handshake.
  task automatic applyStimulus(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic pt,
                               input logic [31:0] ptgt, input logic e_taken,
                               input logic [31:0] e_target, input logic [31:0] e_redirect,
                               input logic e_mis, input logic e_ill, input logic e_misal);
    int waited;
    @(negedge clk);
    out_ready = 1'b0;
    drive(inst, pc, rs1, rs2, pt, ptgt);
    in_valid = 1'b1;
    checkOutput({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, ".out_valid"}, out_valid, 1);
    checkOutput({tag, ".latency"}, waited, 1);
    checkOutput({tag, ".taken"}, out_taken, e_taken);
    checkOutput({tag, ".target"}, out_target, e_target);
    checkOutput({tag, ".redirect"}, out_redirect_pc, e_redirect);
    checkOutput({tag, ".mispredict"}, out_mispredict, e_mis);
    checkOutput({tag, ".illegal"}, out_illegal, e_ill);
    checkOutput({tag, ".misaligned"}, out_misaligned, e_misal);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] got [8];
  int n_got;
  int n_acc;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset.out_valid", out_valid, 0);
    checkOutput("reset.in_ready", in_ready, 1);
    checkOutput("reset.target", out_target, 0);
    checkOutput("reset.redirect", out_redirect_pc, 0);
    checkOutput("reset.branches", stat_branches, 0);
    checkOutput("reset.mispredicts", stat_mispredicts, 0);

    applyStimulus("beq", b_inst(3'b000, 13'd8), 32'h1000, 32'h5, 32'h5, 1'b0, 32'h0,
                  1'b1, 32'h1008, 32'h1008, 1'b1, 1'b0, 1'b0);
    checkOutput("beq.branches", stat_branches, 1);
    checkOutput("beq.mispredicts", stat_mispredicts, 1);

    applyStimulus("blt", b_inst(3'b100, 13'd16), 32'h2000, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h2010,
                  1'b1, 32'h2010, 32'h2010, 1'b0, 1'b0, 1'b0);
    applyStimulus("bltu", b_inst(3'b110, 13'd16), 32'h3000, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,
                  1'b0, 32'h3010, 32'h3004, 1'b0, 1'b0, 1'b0);
    checkOutput("bltu.branches", stat_branches, 3);
    applyStimulus("back", b_inst(3'b000, 13'h1FFC), 32'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC,
                  1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    checkOutput("back.branches_sat", stat_branches, 3);
    checkOutput("back.mispredicts", stat_mispredicts, 1);

    reset_dut();
    #1;
    checkOutput("rst1.branches", stat_branches, 0);
    checkOutput("rst1.out_valid", out_valid, 0);

    applyStimulus("bne_misal", b_inst(3'b001, 13'd6), 32'h100, 32'h1, 32'h2, 1'b1, 32'h106,
                  1'b1, 32'h106, 32'h106, 1'b0, 1'b0, 1'b1);
    applyStimulus("ill_f3", b_inst(3'b010, 13'd8), 32'h400, 32'h1, 32'h1, 1'b1, 32'h408,
                  1'b0, 32'h408, 32'h404, 1'b0, 1'b1, 1'b0);
    applyStimulus("ill_op", 32'h0010_0093, 32'h500, 32'h0, 32'h0, 1'b1, 32'h0,
                  1'b0, 32'hD00, 32'h504, 1'b0, 1'b1, 1'b0);
    checkOutput("ill.branches", stat_branches, 1);
    checkOutput("ill.mispredicts", stat_mispredicts, 0);
    applyStimulus("bge", b_inst(3'b101, 13'd8), 32'h600, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,
                  1'b0, 32'h608, 32'h604, 1'b0, 1'b0, 1'b0);
    applyStimulus("bgeu", b_inst(3'b111, 13'd8), 32'h700, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,
                  1'b1, 32'h708, 32'h708, 1'b1, 1'b0, 1'b0);

    // Saturation with five mispredicted legal branches.
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      applyStimulus("sat", b_inst(3'b000, 13'd8), 32'h800, 32'h7, 32'h7, 1'b0, 32'h0,
                    1'b1, 32'h808, 32'h808, 1'b1, 1'b0, 1'b0);
      if (k == 2) begin
        checkOutput("sat3.branches", stat_branches, 3);
        checkOutput("sat3.mispredicts", stat_mispredicts, 3);
      end
    end
    checkOutput("sat5.branches", stat_branches, 3);
    checkOutput("sat5.mispredicts", stat_mispredicts, 3);

    // Full throughput with out_ready held high.
    reset_dut();
    out_ready = 1'b1;
    n_got = 0; n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid && n_got < 8) begin got[n_got] = out_target; n_got++; end
      if (c < 4) begin
        drive(b_inst(3'b000, 13'd8), (n_acc + 1) << 12, 32'h0, 32'h0, 1'b0, 32'h0);
        in_valid = 1'b1;
        if (in_ready) n_acc++;
      end else in_valid = 1'b0;
    end
    checkOutput("thru.accepted", n_acc, 4);
    checkOutput("thru.outputs", n_got, 4);
    for (int i = 0; i < 4; i++) checkOutput("thru.order", got[i], ((i + 1) << 12) + 8);

    // Backpressure: only two entries fit, then release and drain in order.
    reset_dut();
    n_got = 0; n_acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(b_inst(3'b000, 13'd8), (n_acc + 1) << 8, 32'h0, 32'h0, 1'b0, 32'h0);
      in_valid = 1'b1;
      if (in_ready) n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp.accepted", n_acc, 2);
    checkOutput("bp.in_ready_low", in_ready, 0);
    checkOutput("bp.held_target", out_target, 32'h108);
    out_ready = 1'b1;
    #1;
    checkOutput("bp.in_ready_release", in_ready, 1);
    for (int c = 0; c < 6; c++) begin
      if (out_valid && n_got < 8) begin got[n_got] = out_target; n_got++; end
      @(negedge clk);
    end
    checkOutput("bp.outputs", n_got, 2);
    checkOutput("bp.first", got[0], 32'h108);
    checkOutput("bp.second", got[1], 32'h208);

    // Flush with two entries in flight; the input offered during flush is dropped.
    reset_dut();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(b_inst(3'b000, 13'd8), 32'h900 + c * 32'h100, 32'h0, 32'h0, 1'b0, 32'h0);
      in_valid = 1'b1;
    end
    @(negedge clk);
    checkOutput("flush.pre_valid", out_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush.out_valid", out_valid, 0);
    out_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) n_got++;
    end
    checkOutput("flush.no_output", n_got, 0);

    // A handshake in the flush cycle still counts.
    reset_dut();
    @(negedge clk);
    drive(b_inst(3'b000, 13'd8), 32'hA00, 32'h0, 32'h0, 1'b0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flushhs.valid", out_valid, 1);
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0;
    checkOutput("flushhs.branches", stat_branches, 1);
    checkOutput("flushhs.mispredicts", stat_mispredicts, 1);

    // Reset together with flush while an entry waits at the output.
    @(negedge clk);
    drive(b_inst(3'b000, 13'd8), 32'hB00, 32'h0, 32'h0, 1'b0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    checkOutput("rstflush.out_valid", out_valid, 0);
    checkOutput("rstflush.target", out_target, 0);
    checkOutput("rstflush.branches", stat_branches, 0);
    checkOutput("rstflush.in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, parametrised branch decode-and-resolve unit for the execute stage. It accepts a conditional-branch (B-type) instruction together with its PC, both source operands and the front-end prediction. It decodes the instruction, evaluates the condition, computes the target, and returns taken/target/mispredict/redirect information after a configurable number of register stages. Input and output use valid/ready handshakes, a flush input is provided, and saturating branch/mispredict statistics are kept.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- STAGES, 2: pipeline depth; 1 or 2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all in-flight entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  unit can accept an input entry.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  instruction PC.
- in_rs1, in_rs2  in  XLEN  source operand values.
- in_pred_taken  in  1  front-end predicted taken.
- in_pred_target  in  XLEN  front-end predicted target.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  branch resolved taken.
- out_target  out  XLEN  computed branch target.
- out_redirect_pc  out  XLEN  correct next PC: target if taken, else pc+4.
- out_mispredict  out  1  front end must be redirected.
- out_illegal  out  1  not a valid B-type instruction.
- out_misaligned  out  1  taken target with bit 1 set.
- stat_branches  out  CNT_W  resolved legal branches.
- stat_mispredicts  out  CNT_W  resolved mispredicts.

## Operation
**Decode**
- Legal only if in_inst[6:0]==7'b1100011 and funct3=in_inst[14:12] is not 010 or 011.
- funct3 mapping: 000 BEQ (==), 001 BNE (!=), 100 BLT (signed <), 101 BGE (signed >=), 110 BLTU (unsigned <), 111 BGEU (unsigned >=).
- Immediate: imm13 = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}, sign-extended to XLEN.

**Arithmetic**
- target = in_pc + sext(imm13), modulo 2^XLEN (wraps).
- pc+4 also wraps modulo 2^XLEN.
- Comparisons use all XLEN bits.

**Resolution**
- out_taken = legal && condition.
- out_mispredict = legal && (in_pred_taken != taken || (taken && in_pred_target != target)).
- out_misaligned = taken && target[1].
- Illegal entry: taken=0, mispredict=0, misaligned=0, illegal=1. out_target and out_redirect_pc still carry the computed values.

**Pipeline**
- STAGES=1: one output register holds the complete result.
- STAGES=2: stage 1 registers the decoded fields, imm, target, pc+4 and compare outcome; stage 2 registers the mispredict/misaligned results.
- Each stage is valid-bit tracked and loads when empty or when its contents move forward in the same cycle.
- in_ready = !stage1_valid || stage1_advances, where stage1_advances is computed combinationally back from out_ready. No bubbles at full throughput.
- Outputs hold stable while out_valid && !out_ready.

**Flush**
- All stage valid bits clear at the next edge.
- An input presented in the flush cycle is discarded.
- An output handshake in the flush cycle still counts.

**Statistics**
- On each output handshake (out_valid && out_ready) of a legal entry, stat_branches increments.
- stat_mispredicts increments when that entry also has out_mispredict=1.
- Both counters saturate at 2^CNT_W-1.

## Timing
- Reset: all valid bits, both counters and every output register are 0, so out_valid=0 and all result outputs=0. in_ready=1 in the first cycle after reset deasserts.
- Latency: an entry accepted at edge N has out_valid=1 after edge N+STAGES-1, and is visible in that cycle when out_ready was high.
- Throughput: one entry per cycle while out_ready=1.
- Backpressure: with out_ready=0, the pipeline fills after STAGES accepts, then in_ready=0. When out_ready returns to 1, in_ready=1 in that same cycle.
- Simultaneous flush and rst: rst dominates; the result is identical to reset alone.
- Reset mid-operation: all in-flight entries are dropped and the counters clear.

## Test plan
- BEQ, rs1=rs2=0x5, pc=0x1000, imm=+8, pred_taken=0 -> taken=1, target=0x1008, redirect=0x1008, mispredict=1; after handshake stat_branches=1, stat_mispredicts=1.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> taken=1. BLTU with the same operands -> taken=0; with pred_taken=0 -> mispredict=0, redirect=pc+4.
- Backward branch pc=0x0, imm=-4 (XLEN=32) -> target=0xFFFFFFFC, no error flag. BNE with imm=+6 and taken -> out_misaligned=1.
- funct3=010 or opcode 0x13 -> out_illegal=1, taken=0, mispredict=0, counters unchanged.
- STAGES=2, continuous input, out_ready held 0 for 5 cycles -> exactly 2 entries accepted, then in_ready=0. Release out_ready -> results appear in order, no loss or duplication. Assert flush with 2 entries in flight -> out_valid=0 on the next cycle.
- CNT_W=2, 5 legal mispredicted branches -> both counters read 3 and stay at 3. rst pulse -> counters 0 and out_valid=0 on the next cycle.
